// File: rtl/tge_tx_mux_pkg.sv
// Shared types and helpers for the frame-atomic TX merger.
package tge_tx_mux_pkg;

    // Descriptor field widths (the length field width follows DEPTH_LOG2).
    localparam int IP_W   = 32;
    localparam int PORT_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_t;

    // Round-robin pick: first set request after 'last', wrapping modulo n_chan.
    // Returns 'last' when nothing is requested.
    function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] last,
                                           input logic [3:0] n_chan);
        logic [2:0] pick;
        logic       found;
        logic       hit;
        logic [4:0] sum;
        logic [4:0] idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            sum   = 5'(last) + 5'(k);
            idx   = (sum >= 5'(n_chan)) ? (sum - 5'(n_chan)) : sum;
            hit   = (k <= int'(n_chan)) && !found && req[idx[2:0]];
            pick  = hit ? idx[2:0] : pick;
            found = found | hit;
        end
        return pick;
    endfunction

endpackage

// File: rtl/tge_chan_buf.sv
// Per-channel frame buffer: data RAM, descriptor FIFO, commit/rewind writer
// and sticky overflow. Only committed (complete) frames are visible to the reader.
module tge_chan_buf
    import tge_tx_mux_pkg::*;
#(
    parameter int DW         = 64,
    parameter int DEPTH_LOG2 = 9,
    parameter int META_LOG2  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    input  logic                  wr_eof,
    input  logic [DW-1:0]         wr_data,
    input  logic [IP_W-1:0]       wr_ip,
    input  logic [PORT_W-1:0]     wr_port,
    output logic                  overflow,
    input  logic                  ovf_ack,
    output logic                  afull,
    input  logic                  rd_en,
    output logic [DW-1:0]         rd_data,
    output logic                  desc_valid,
    output logic [IP_W-1:0]       desc_ip,
    output logic [PORT_W-1:0]     desc_port,
    output logic [DEPTH_LOG2:0]   desc_len,
    input  logic                  desc_pop
);

    localparam int DEPTH      = 2 ** DEPTH_LOG2;
    localparam int META_DEPTH = 2 ** META_LOG2;
    localparam int LW         = DEPTH_LOG2 + 1;
    localparam int MW         = META_LOG2 + 1;
    localparam int DESC_W     = IP_W + PORT_W + LW;

    localparam logic [LW-1:0] ONE_L        = LW'(1);
    localparam logic [LW-1:0] DEPTH_L      = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_THR    = LW'(DEPTH - DEPTH / 4);
    localparam logic [MW-1:0] MONE_L       = MW'(1);
    localparam logic [MW-1:0] META_DEPTH_L = MW'(META_DEPTH);

    logic [DW-1:0]     mem      [DEPTH];
    logic [DESC_W-1:0] desc_mem [META_DEPTH];

    logic [LW-1:0] wr_ptr_r;
    logic [LW-1:0] commit_ptr_r;
    logic [LW-1:0] rd_ptr_r;
    logic [LW-1:0] frame_len_r;
    logic [MW-1:0] mwr_r;
    logic [MW-1:0] mrd_r;
    logic          dropping_r;
    logic          overflow_r;
    logic [DW-1:0] rd_data_r;

    logic [LW-1:0]     used_s;
    logic              data_full_s;
    logic              desc_full_s;
    logic              accept_s;
    logic              drop_s;
    logic              commit_s;
    logic [DESC_W-1:0] desc_head_s;

    // Write-side decision: accept the word, or drop the whole frame in progress.
    always_comb begin
        used_s      = wr_ptr_r - rd_ptr_r;
        data_full_s = (used_s == DEPTH_L);
        desc_full_s = ((mwr_r - mrd_r) == META_DEPTH_L);
        accept_s    = 1'b0;
        drop_s      = 1'b0;
        commit_s    = 1'b0;
        if (wr_valid && !dropping_r) begin
            if (data_full_s || (frame_len_r == DEPTH_L) || (wr_eof && desc_full_s)) begin
                drop_s = 1'b1;
            end else begin
                accept_s = 1'b1;
                commit_s = wr_eof;
            end
        end else begin
            accept_s = 1'b0;
        end
    end

    // Write pointer, commit point, frame length, discard mode and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r     <= '0;
            commit_ptr_r <= '0;
            frame_len_r  <= '0;
            mwr_r        <= '0;
            dropping_r   <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            if (drop_s) begin
                // Rewind; if the drop hit mid-frame, swallow the rest up to EOF.
                wr_ptr_r    <= commit_ptr_r;
                frame_len_r <= '0;
                dropping_r  <= !wr_eof;
            end else if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_L;
                if (commit_s) begin
                    commit_ptr_r <= wr_ptr_r + ONE_L;
                    frame_len_r  <= '0;
                    mwr_r        <= mwr_r + MONE_L;
                end else begin
                    frame_len_r <= frame_len_r + ONE_L;
                end
            end else if (wr_valid && dropping_r && wr_eof) begin
                dropping_r <= 1'b0;
            end
            // A new drop outranks an acknowledge arriving in the same cycle.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_ack) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Storage arrays: data words and descriptors written on acceptance/commit.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem[wr_ptr_r[DEPTH_LOG2-1:0]] <= wr_data;
        end
        if (commit_s) begin
            desc_mem[mwr_r[META_LOG2-1:0]] <= {wr_ip, wr_port, frame_len_r + ONE_L};
        end
    end

    // Read side: one-cycle registered RAM read and descriptor pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r  <= '0;
            rd_data_r <= '0;
            mrd_r     <= '0;
        end else begin
            if (rd_en) begin
                rd_data_r <= mem[rd_ptr_r[DEPTH_LOG2-1:0]];
                rd_ptr_r  <= rd_ptr_r + ONE_L;
            end
            if (desc_pop) begin
                mrd_r <= mrd_r + MONE_L;
            end
        end
    end

    assign desc_head_s = desc_mem[mrd_r[META_LOG2-1:0]];
    assign desc_valid  = (mwr_r != mrd_r);
    assign desc_len    = desc_head_s[LW-1:0];
    assign desc_port   = desc_head_s[LW +: PORT_W];
    assign desc_ip     = desc_head_s[LW + PORT_W +: IP_W];
    assign rd_data     = rd_data_r;
    assign overflow    = overflow_r;
    assign afull       = (used_s > AFULL_THR) || desc_full_s;

endmodule

// File: rtl/tge_tx_mux.sv
// N-channel frame-atomic merger in front of the 10GbE application TX port.
// Round-robin between channels holding complete frames; one frame at a time.
module tge_tx_mux
    import tge_tx_mux_pkg::*;
#(
    parameter int N_CHAN     = 4,
    parameter int DW         = 64,
    parameter int DEPTH_LOG2 = 9,
    parameter int META_LOG2  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CHAN-1:0]      in_valid,
    input  logic [N_CHAN-1:0]      in_end_of_frame,
    input  logic [N_CHAN*DW-1:0]   in_data,
    input  logic [N_CHAN*32-1:0]   in_dest_ip,
    input  logic [N_CHAN*16-1:0]   in_dest_port,
    output logic [N_CHAN-1:0]      in_overflow,
    input  logic [N_CHAN-1:0]      in_overflow_ack,
    output logic [N_CHAN-1:0]      in_afull,
    output logic                   out_valid,
    output logic                   out_end_of_frame,
    output logic [DW-1:0]          out_data,
    output logic [31:0]            out_dest_ip,
    output logic [15:0]            out_dest_port,
    input  logic                   out_afull
);

    localparam int CW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int LW = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0] ONE_L = LW'(1);

    logic [N_CHAN-1:0] desc_valid_s;
    logic [N_CHAN-1:0] rd_en_s;
    logic [N_CHAN-1:0] pop_s;
    logic [DW-1:0]     ch_rd_data_s [N_CHAN];
    logic [IP_W-1:0]   ch_ip_s      [N_CHAN];
    logic [PORT_W-1:0] ch_port_s    [N_CHAN];
    logic [LW-1:0]     ch_len_s     [N_CHAN];

    arb_state_t        state_r;
    arb_state_t        state_s;
    logic [CW-1:0]     rr_r;         // rr pointer, also the channel being sent
    logic [CW-1:0]     pick_s;
    logic [LW-1:0]     len_r;
    logic [LW-1:0]     rd_cnt_r;
    logic [IP_W-1:0]   ip_r;
    logic [PORT_W-1:0] port_r;
    logic              out_valid_r;
    logic              out_eof_r;
    logic              afull_q_r;
    logic              grant_fire_s;
    logic              read_s;
    logic              last_s;

    genvar gi;
    generate
        for (gi = 0; gi < N_CHAN; gi++) begin : g_chan
            tge_chan_buf #(
                .DW         (DW),
                .DEPTH_LOG2 (DEPTH_LOG2),
                .META_LOG2  (META_LOG2)
            ) u_buf (
                .clk        (clk),
                .rst_n      (rst_n),
                .wr_valid   (in_valid[gi]),
                .wr_eof     (in_end_of_frame[gi]),
                .wr_data    (in_data[gi*DW +: DW]),
                .wr_ip      (in_dest_ip[gi*IP_W +: IP_W]),
                .wr_port    (in_dest_port[gi*PORT_W +: PORT_W]),
                .overflow   (in_overflow[gi]),
                .ovf_ack    (in_overflow_ack[gi]),
                .afull      (in_afull[gi]),
                .rd_en      (rd_en_s[gi]),
                .rd_data    (ch_rd_data_s[gi]),
                .desc_valid (desc_valid_s[gi]),
                .desc_ip    (ch_ip_s[gi]),
                .desc_port  (ch_port_s[gi]),
                .desc_len   (ch_len_s[gi]),
                .desc_pop   (pop_s[gi])
            );
        end
    endgenerate

    // Arbiter next state: grant in IDLE, stream reads in SEND gated by registered out_afull.
    always_comb begin
        state_s      = state_r;
        grant_fire_s = 1'b0;
        read_s       = 1'b0;
        last_s       = (rd_cnt_r == (len_r - ONE_L));
        pick_s       = CW'(rr_pick(8'(desc_valid_s), 3'(rr_r), 4'(N_CHAN)));
        case (state_r)
            ST_IDLE: begin
                if (|desc_valid_s) begin
                    grant_fire_s = 1'b1;
                    state_s      = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!afull_q_r) begin
                    read_s  = 1'b1;
                    state_s = last_s ? ST_IDLE : ST_SEND;
                end else begin
                    state_s = ST_SEND;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Steer read and pop strobes to the granted channel only.
    always_comb begin
        rd_en_s = '0;
        pop_s   = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (rr_r == CW'(i)) begin
                rd_en_s[i] = read_s;
                pop_s[i]   = read_s && last_s;
            end else begin
                rd_en_s[i] = 1'b0;
                pop_s[i]   = 1'b0;
            end
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant latch, word counter and registered output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_r        <= '0;
            len_r       <= '0;
            rd_cnt_r    <= '0;
            ip_r        <= '0;
            port_r      <= '0;
            out_valid_r <= 1'b0;
            out_eof_r   <= 1'b0;
            afull_q_r   <= 1'b0;
        end else begin
            afull_q_r   <= out_afull;
            out_valid_r <= read_s;
            out_eof_r   <= read_s && last_s;
            if (grant_fire_s) begin
                rr_r     <= pick_s;
                len_r    <= ch_len_s[pick_s];
                ip_r     <= ch_ip_s[pick_s];
                port_r   <= ch_port_s[pick_s];
                rd_cnt_r <= '0;
            end else if (read_s) begin
                rd_cnt_r <= rd_cnt_r + ONE_L;
            end
        end
    end

    assign out_valid        = out_valid_r;
    assign out_end_of_frame = out_eof_r;
    assign out_data         = ch_rd_data_s[rr_r];
    assign out_dest_ip      = ip_r;
    assign out_dest_port    = port_r;

endmodule

// File: tb/tb_tge_tx_mux.sv
// Self-checking bench for tge_tx_mux: table of single-channel frames, then
// hand-written sequences for arbitration order, drops, backpressure and reset.
module tb_tge_tx_mux;

    localparam int N     = 4;
    localparam int DW    = 64;
    localparam int DL    = 9;
    localparam int ML    = 3;
    localparam int DEPTH = 2 ** DL;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_eof = '0;
    logic [N*DW-1:0] in_data = '0;
    logic [N*32-1:0] in_ip = '0;
    logic [N*16-1:0] in_port = '0;
    logic [N-1:0]    in_overflow;
    logic [N-1:0]    ack = '0;
    logic [N-1:0]    in_afull;
    logic            out_valid;
    logic            out_eof;
    logic [DW-1:0]   out_data;
    logic [31:0]     out_ip;
    logic [15:0]     out_port;
    logic            out_afull = 1'b0;

    typedef struct {
        logic [63:0] data;
        logic        eof;
        logic [31:0] ip;
        logic [15:0] port;
    } exp_t;

    typedef struct {
        int          ch;
        int          len;
        int          fid;
        logic [31:0] ip_base;
        logic [15:0] port_base;
        logic [3:0]  exp_ovf;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   prev_eof_cyc = 0;
    bit   have_prev = 1'b0;
    bit   new_frame = 1'b1;
    bit   gap_check = 1'b0;

    tge_tx_mux #(
        .N_CHAN     (N),
        .DW         (DW),
        .DEPTH_LOG2 (DL),
        .META_LOG2  (ML)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_end_of_frame  (in_eof),
        .in_data          (in_data),
        .in_dest_ip       (in_ip),
        .in_dest_port     (in_port),
        .in_overflow      (in_overflow),
        .in_overflow_ack  (ack),
        .in_afull         (in_afull),
        .out_valid        (out_valid),
        .out_end_of_frame (out_eof),
        .out_data         (out_data),
        .out_dest_ip      (out_ip),
        .out_dest_port    (out_port),
        .out_afull        (out_afull)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] mk_data(input int ch, input int fid, input int k);
        return {8'(ch), 24'(fid), 32'(k)};
    endfunction

    task automatic push_exp(input int ch, input int len, input int fid,
                            input logic [31:0] ip_base, input logic [15:0] port_base);
        exp_t e;
        for (int k = 0; k < len; k++) begin
            e.data = mk_data(ch, fid, k);
            e.eof  = (k == len - 1);
            e.ip   = ip_base + 32'(ch);
            e.port = port_base + 16'(ch);
            exp_q.push_back(e);
        end
    endtask

    // Drives one frame on every channel in mask; ip/port are garbage except on EOF.
    task automatic send_multi(input logic [N-1:0] mask, input int len, input int fid,
                              input logic [31:0] ip_base, input logic [15:0] port_base);
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            for (int c = 0; c < N; c++) begin
                if (mask[c]) begin
                    in_valid[c]         = 1'b1;
                    in_eof[c]           = (k == len - 1);
                    in_data[c*DW +: DW] = mk_data(c, fid, k);
                    in_ip[c*32 +: 32]   = (k == len - 1) ? ip_base + 32'(c) : ~ip_base;
                    in_port[c*16 +: 16] = (k == len - 1) ? port_base + 16'(c) : ~port_base;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = '0;
        in_eof   = '0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
    endtask

    task automatic pulse_ack(input logic [N-1:0] mask);
        @(posedge clk);
        #1;
        ack = mask;
        @(posedge clk);
        #1;
        ack = '0;
    endtask

    // Output monitor: scoreboard pop, EOF qualification and inter-frame gap.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!out_valid && out_eof) begin
                chk("eof_without_valid", 64'(out_eof), 64'd0);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_eof", 64'(out_eof), 64'(e.eof));
                    chk("out_ip", 64'(out_ip), 64'(e.ip));
                    chk("out_port", 64'(out_port), 64'(e.port));
                end
                if (gap_check && have_prev && new_frame) begin
                    chk("frame_gap", 64'(cyc - prev_eof_cyc), 64'd2);
                end
                new_frame = out_eof;
                if (out_eof) begin
                    prev_eof_cyc = cyc;
                    have_prev    = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        int   n;
        int   cnt;
        tbl[0] = '{ch: 0, len: 3, fid: 1, ip_base: 32'h0A00_0001, port_base: 16'h1234, exp_ovf: 4'b0000};
        tbl[1] = '{ch: 2, len: 1, fid: 2, ip_base: 32'hC0A8_0100, port_base: 16'h5000, exp_ovf: 4'b0000};
        tbl[2] = '{ch: 1, len: 4, fid: 3, ip_base: 32'h0A0A_0A00, port_base: 16'h0100, exp_ovf: 4'b0000};
        tbl[3] = '{ch: 3, len: 6, fid: 4, ip_base: 32'hAC10_0000, port_base: 16'hBEE0, exp_ovf: 4'b0000};
        tbl[4] = '{ch: 3, len: 2, fid: 5, ip_base: 32'h7F00_0000, port_base: 16'h0050, exp_ovf: 4'b0000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_eof", 64'(out_eof), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_ip", 64'(out_ip), 64'd0);
        chk("rst_out_port", 64'(out_port), 64'd0);
        chk("rst_overflow", 64'(in_overflow), 64'd0);
        chk("rst_in_afull", 64'(in_afull), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Table of single-channel frames, each drained before the next
        for (int i = 0; i < 5; i++) begin
            push_exp(tbl[i].ch, tbl[i].len, tbl[i].fid, tbl[i].ip_base, tbl[i].port_base);
            send_multi(4'b0001 << tbl[i].ch, tbl[i].len, tbl[i].fid, tbl[i].ip_base, tbl[i].port_base);
            wait_drain($sformatf("vec%0d_drain", i), 200);
            chk($sformatf("vec%0d_ovf", i), 64'(in_overflow), 64'(tbl[i].exp_ovf));
        end

        // All four channels loaded together while stalled; rr=3 so order is 0,1,2,3
        @(posedge clk);
        #1;
        out_afull = 1'b1;
        have_prev = 1'b0;
        new_frame = 1'b1;
        gap_check = 1'b1;
        for (int c = 0; c < N; c++) begin
            push_exp(c, 2, 10, 32'h0B00_0000, 16'h2000);
        end
        send_multi(4'b1111, 2, 10, 32'h0B00_0000, 16'h2000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rr_stalled_no_output", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        out_afull = 1'b0;
        wait_drain("rr_drain", 200);
        gap_check = 1'b0;

        // Oversize frame on ch1 is dropped; the next frame survives; ack clears
        send_multi(4'b0010, DEPTH + 1, 20, 32'h0C00_0000, 16'h3000);
        repeat (2) @(negedge clk);
        chk("oversize_ovf_set", 64'(in_overflow[1]), 64'd1);
        chk("oversize_ovf_others", 64'(in_overflow & 4'b1101), 64'd0);
        push_exp(1, 4, 21, 32'h0C00_0100, 16'h3100);
        send_multi(4'b0010, 4, 21, 32'h0C00_0100, 16'h3100);
        wait_drain("after_drop_drain", 200);
        chk("ovf_sticky", 64'(in_overflow[1]), 64'd1);
        pulse_ack(4'b0010);
        @(negedge clk);
        chk("ovf_ack_clear", 64'(in_overflow[1]), 64'd0);

        // Backpressure mid-frame: at most one word after out_afull rises
        push_exp(2, 20, 30, 32'h0D00_0000, 16'h4000);
        send_multi(4'b0100, 20, 30, 32'h0D00_0000, 16'h4000);
        n = 0;
        while (exp_q.size() > 15 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_frame_started", 64'(exp_q.size() <= 15), 64'd1);
        @(posedge clk);
        #1;
        out_afull = 1'b1;
        @(negedge clk);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("bp_extra_words", 64'(cnt <= 1), 64'd1);
        chk("bp_stopped", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        out_afull = 1'b0;
        wait_drain("bp_drain", 200);

        // Descriptor FIFO full: eight queued, ninth dropped, queued ones delivered
        @(posedge clk);
        #1;
        out_afull = 1'b1;
        for (int f = 0; f < 8; f++) begin
            push_exp(0, 2, 40 + f, 32'h0E00_0000 + 32'(f), 16'h5000);
            send_multi(4'b0001, 2, 40 + f, 32'h0E00_0000 + 32'(f), 16'h5000);
        end
        send_multi(4'b0001, 2, 48, 32'h0E00_00FF, 16'h5000);
        repeat (2) @(negedge clk);
        chk("descfull_ovf", 64'(in_overflow[0]), 64'd1);
        chk("descfull_afull", 64'(in_afull[0]), 64'd1);
        pulse_ack(4'b0001);
        @(negedge clk);
        chk("descfull_ack", 64'(in_overflow[0]), 64'd0);
        @(posedge clk);
        #1;
        out_afull = 1'b0;
        wait_drain("descfull_drain", 300);
        @(negedge clk);
        chk("descfull_afull_clear", 64'(in_afull[0]), 64'd0);

        // Reset while a frame is being sent; outputs clear at once
        push_exp(3, 10, 60, 32'h0F00_0000, 16'h6000);
        send_multi(4'b1000, 10, 60, 32'h0F00_0000, 16'h6000);
        n = 0;
        while (exp_q.size() > 6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reset_frame_started", 64'(exp_q.size() <= 6), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_eof", 64'(out_eof), 64'd0);
        chk("async_rst_data", out_data, 64'd0);
        chk("async_rst_ip", 64'(out_ip), 64'd0);
        chk("async_rst_port", 64'(out_port), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        push_exp(1, 3, 61, 32'h0A00_0009, 16'h7000);
        send_multi(4'b0010, 3, 61, 32'h0A00_0009, 16'h7000);
        wait_drain("post_reset_drain", 200);
        chk("post_reset_ovf", 64'(in_overflow), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
